// File: rtl/fifo_scd_prog.sv
// Single-clock flop-array FIFO with optional first-word-fall-through, occupancy count,
// programmable almost thresholds, synchronous flush and sticky overflow/underflow flags.

module fifo_scd_prog_chk #(
   parameter int aw    = 4,
   parameter int af_th = (1 << aw) - 2,
   parameter int ae_th = 1
) ();
   generate
      if (aw < 1 || af_th < 1 || af_th > (1 << aw) || ae_th < 0 || ae_th > (1 << aw) - 1) begin : g_bad_param
         $error("fifo_scd_prog: illegal aw/af_th/ae_th combination");
      end
   endgenerate
endmodule

module fifo_scd_prog #(
   parameter int aw    = 4,
   parameter int dw    = 32,
   parameter int fwft  = 0,
   parameter int af_th = (1 << aw) - 2,
   parameter int ae_th = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [dw-1:0] din,
   input  logic          wen,
   input  logic          ren,
   input  logic          flush,
   input  logic          clr_err,
   output logic [dw-1:0] dout,
   output logic          dout_vld,
   output logic          empty,
   output logic          full,
   output logic          almost_empty,
   output logic          almost_full,
   output logic [aw:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam int          depth   = 1 << aw;
   localparam logic [aw:0] depth_c = (aw+1)'(depth);
   localparam logic [aw:0] af_th_c = (aw+1)'(af_th);
   localparam logic [aw:0] ae_th_c = (aw+1)'(ae_th);
   localparam logic        af_rst  = (af_th == 0) ? 1'b1 : 1'b0;

   fifo_scd_prog_chk #(.aw(aw), .af_th(af_th), .ae_th(ae_th)) u_chk ();

   logic [dw-1:0] mem_r [depth];
   logic [aw:0]   rp_r;
   logic [aw:0]   wp_r;
   logic [aw:0]   count_r;
   logic          empty_r;
   logic          full_r;
   logic          ae_r;
   logic          af_r;
   logic          ovf_r;
   logic          unf_r;

   logic          rd_ok_s;
   logic          rd_en_s;
   logic          wr_en_s;
   logic          ovf_set_s;
   logic          unf_set_s;
   logic [aw:0]   count_next_s;

   // Accept/reject decisions; flush suppresses both transfers and error reporting.
   always_comb begin
      rd_ok_s      = ren && !empty_r;
      rd_en_s      = 1'b0;
      wr_en_s      = 1'b0;
      ovf_set_s    = 1'b0;
      unf_set_s    = 1'b0;
      count_next_s = count_r;
      if (flush) begin
         count_next_s = '0;
      end else begin
         rd_en_s      = rd_ok_s;
         wr_en_s      = wen && (!full_r || rd_ok_s);
         ovf_set_s    = wen && !(!full_r || rd_ok_s);
         unf_set_s    = ren && !rd_ok_s;
         count_next_s = count_r + (aw+1)'(wr_en_s) - (aw+1)'(rd_en_s);
      end
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wp_r[aw-1:0]] <= din;
      end
   end

   // Pointers, occupancy and occupancy-derived flags, all from next-state count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_r    <= '0;
         wp_r    <= '0;
         count_r <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         ae_r    <= 1'b1;
         af_r    <= af_rst;
      end else begin
         if (flush) begin
            rp_r <= '0;
            wp_r <= '0;
         end else begin
            if (rd_en_s) begin
               rp_r <= rp_r + (aw+1)'(1);
            end
            if (wr_en_s) begin
               wp_r <= wp_r + (aw+1)'(1);
            end
         end
         count_r <= count_next_s;
         empty_r <= (count_next_s == (aw+1)'(0));
         full_r  <= (count_next_s == depth_c);
         ae_r    <= (count_next_s <= ae_th_c);
         af_r    <= (count_next_s >= af_th_c);
      end
   end

   // Sticky error flags: a new error wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (clr_err) begin
            ovf_r <= 1'b0;
         end
         if (unf_set_s) begin
            unf_r <= 1'b1;
         end else if (clr_err) begin
            unf_r <= 1'b0;
         end
      end
   end

   generate
      if (fwft == 0) begin : g_std
         logic [dw-1:0] dout_r;
         logic          vld_r;

         // Registered read port: one-cycle latency, dout holds between pops.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_r <= '0;
               vld_r  <= 1'b0;
            end else begin
               if (rd_en_s) begin
                  dout_r <= mem_r[rp_r[aw-1:0]];
               end
               vld_r <= rd_en_s;
            end
         end

         assign dout     = dout_r;
         assign dout_vld = vld_r;
      end else begin : g_fwft
         assign dout     = mem_r[rp_r[aw-1:0]];
         assign dout_vld = !empty_r;
      end
   endgenerate

   assign count        = count_r;
   assign empty        = empty_r;
   assign full         = full_r;
   assign almost_empty = ae_r;
   assign almost_full  = af_r;
   assign overflow     = ovf_r;
   assign underflow    = unf_r;

endmodule

// File: tb/tb_fifo_scd_prog.sv
// Bench for fifo_scd_prog: standard and FWFT instances share stimulus and are checked
// every cycle against a queue-based model, plus literal expectations from directed steps.
`timescale 1ns/1ps
module tb_fifo_scd_prog;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = 8'h00;
   logic          wen = 1'b0, ren = 1'b0, flush = 1'b0, clr_err = 1'b0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_vld, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
   logic          f_vld, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
   logic [AW:0]   s_count, f_count;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   // reference model
   logic [DW-1:0] q[$];
   bit            m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
   logic [DW-1:0] m_dout = 8'h00;

   fifo_scd_prog #(.aw(AW), .dw(DW), .fwft(0), .af_th(6), .ae_th(1)) u_std (
      .clk(clk), .rst_n(rst_n), .din(din), .wen(wen), .ren(ren), .flush(flush),
      .clr_err(clr_err), .dout(s_dout), .dout_vld(s_vld), .empty(s_empty), .full(s_full),
      .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .overflow(s_ovf),
      .underflow(s_unf));

   fifo_scd_prog #(.aw(AW), .dw(DW), .fwft(1), .af_th(6), .ae_th(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .din(din), .wen(wen), .ren(ren), .flush(flush),
      .clr_err(clr_err), .dout(f_dout), .dout_vld(f_vld), .empty(f_empty), .full(f_full),
      .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .overflow(f_ovf),
      .underflow(f_unf));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_vld  = 1'b0;
      m_dout = 8'h00;
   endtask

   // one clock edge of the FIFO rules, applied to the queue
   task automatic model_step();
      bit rd, wr;
      if (clr_err) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (flush) begin
         q.delete();
         m_vld = 1'b0;
      end else begin
         rd = ren && (q.size() > 0);
         wr = wen && ((q.size() < DEPTH) || rd);
         if (ren && !rd) m_unf = 1'b1;
         if (wen && !wr) m_ovf = 1'b1;
         if (rd) begin
            m_dout = q.pop_front();
            m_vld  = 1'b1;
         end else begin
            m_vld = 1'b0;
         end
         if (wr) q.push_back(din);
      end
   endtask

   task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d,
                      input bit fl = 1'b0, input bit cl = 1'b0);
      wen = w; ren = r; din = d; flush = fl; clr_err = cl;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("s_count", 32'(s_count), 32'(q.size()));
         chk("s_empty", 32'(s_empty), 32'(q.size() == 0));
         chk("s_full", 32'(s_full), 32'(q.size() == DEPTH));
         chk("s_ae", 32'(s_ae), 32'(q.size() <= 1));
         chk("s_af", 32'(s_af), 32'(q.size() >= 6));
         chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
         chk("s_unf", 32'(s_unf), 32'(m_unf));
         chk("s_dout", 32'(s_dout), 32'(m_dout));
         chk("s_vld", 32'(s_vld), 32'(m_vld));
         chk("f_count", 32'(f_count), 32'(q.size()));
         chk("f_empty", 32'(f_empty), 32'(q.size() == 0));
         chk("f_vld", 32'(f_vld), 32'(q.size() > 0));
         chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
         if (q.size() > 0) chk("f_dout", 32'(f_dout), 32'(q[0]));
      end
   end

   initial begin
      #12 rst_n = 1'b1;
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_count", 32'(s_count), 32'd0);
      chk("rst_empty", 32'(s_empty), 32'd1);
      chk("rst_ae", 32'(s_ae), 32'd1);
      chk("rst_af", 32'(s_af), 32'd0);

      // fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         if (i == 1) chk("ae_after1", 32'(s_ae), 32'd1);
         if (i == 2) chk("ae_after2", 32'(s_ae), 32'd0);
         if (i == 5) chk("af_after5", 32'(s_af), 32'd0);
         if (i == 6) chk("af_after6", 32'(s_af), 32'd1);
         if (i == 7) chk("full_after7", 32'(s_full), 32'd0);
      end
      chk("full_count", 32'(s_count), 32'd8);
      chk("full_flag", 32'(s_full), 32'd1);
      cyc(1'b1, 1'b0, 8'h09);
      chk("ovf_set", 32'(s_ovf), 32'd1);
      chk("ovf_count", 32'(s_count), 32'd8);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(s_ovf), 32'd0);

      // drain
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk("rd_dout", 32'(s_dout), 32'(i));
         chk("rd_vld", 32'(s_vld), 32'd1);
      end
      chk("drain_empty", 32'(s_empty), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);
      chk("unf_set", 32'(s_unf), 32'd1);
      chk("unf_dout", 32'(s_dout), 32'h08);
      chk("unf_vld", 32'(s_vld), 32'd0);

      // simultaneous read/write on full
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(i));
      cyc(1'b1, 1'b1, 8'hAA);
      chk("rw_full_count", 32'(s_count), 32'd8);
      chk("rw_full_flag", 32'(s_full), 32'd1);
      chk("rw_full_ovf", 32'(s_ovf), 32'd0);
      chk("rw_full_dout", 32'(s_dout), 32'h01);
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 8'h00);
      chk("aa_eighth", 32'(s_dout), 32'hAA);

      // fall-through
      cyc(1'b1, 1'b0, 8'h5A);
      chk("fwft_empty", 32'(f_empty), 32'd0);
      chk("fwft_dout", 32'(f_dout), 32'h5A);
      chk("fwft_vld", 32'(f_vld), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);
      chk("fwft_empty2", 32'(f_empty), 32'd1);

      // flush beats a same-cycle write, errors retained
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h31 + i));
      chk("pre_flush_cnt", 32'(s_count), 32'd3);
      cyc(1'b1, 1'b0, 8'h77, 1'b1);
      chk("flush_count", 32'(s_count), 32'd0);
      chk("flush_empty", 32'(s_empty), 32'd1);
      chk("flush_ovf", 32'(s_ovf), 32'd0);
      chk("flush_unf", 32'(s_unf), 32'd1);
      chk("flush_vld", 32'(s_vld), 32'd0);
      cyc(1'b1, 1'b0, 8'h11);
      cyc(1'b0, 1'b1, 8'h00);
      chk("post_flush_rd", 32'(s_dout), 32'h11);

      // pointer wrap
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         cyc(1'b0, 1'b1, 8'h00);
         chk("wrap_rd", 32'(s_dout), 32'(i));
      end

      // async reset mid-stream
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
      wen = 1'b1; ren = 1'b1; din = 8'h55;
      @(posedge clk);
      model_step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar_count", 32'(s_count), 32'd0);
      chk("ar_empty", 32'(s_empty), 32'd1);
      chk("ar_full", 32'(s_full), 32'd0);
      chk("ar_ae", 32'(s_ae), 32'd1);
      chk("ar_af", 32'(s_af), 32'd0);
      chk("ar_ovf", 32'(s_ovf), 32'd0);
      chk("ar_unf", 32'(s_unf), 32'd0);
      chk("ar_dout", 32'(s_dout), 32'd0);
      chk("ar_vld", 32'(s_vld), 32'd0);
      chk("ar_f_empty", 32'(f_empty), 32'd1);
      wen = 1'b0; ren = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         cyc($urandom_range(99) < 55, $urandom_range(99) < 50, 8'($urandom),
             $urandom_range(99) < 3, $urandom_range(99) < 4);
      end

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
